cycle_terminator: RTL and testbench
===================================

# cycle_terminator

Terminates every CPU bus cycle on the accelerator side. It merges three acknowledge sources into the single `DTACK_CPU_n` driven to the 68000:
- fast RAM,
- the emulated 6800 cycle (`M6800_DTACK_n` from the 6800/E-clock stage),
- the synchronized Amiga motherboard `/DTACK`.

A watchdog raises `/BERR` when no source answers. It sits directly downstream of the 6800 cycle emulator and the address decoder, and directly upstream of the CPU termination pins.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 128. C7M cycles spent in RUN before `/BERR`. Legal range 4..1023.

Ports:
- `C7M`  in  1  the single clock; all state updates on the falling edge.
- `RESET_n`  in  1  synchronous, active-low reset, sampled on the falling edge of C7M.
- `AS_CPU_n`  in  1  CPU address strobe; asynchronous, synchronized internally.
- `CPUSPACE`  in  1  1 = CPU-space (interrupt acknowledge) cycle.
- `RAM_SEL`  in  1  decoder: cycle targets fast RAM.
- `MB_SEL`  in  1  decoder: cycle targets motherboard.
- `VPA_n`  in  1  valid peripheral address, from decoder or motherboard.
- `RAM_DTACK_n`  in  1  fast RAM ack; already in the C7M domain.
- `M6800_DTACK_n`  in  1  6800-cycle ack; already in the C7M domain.
- `MB_DTACK_n`  in  1  motherboard `/DTACK`; asynchronous.
- `DTACK_CPU_n`  out  1  acknowledge to the CPU.
- `BERR_n`  out  1  bus error to the CPU.
- `BUSY`  out  1  high while in RUN, ACK or FAULT.

## Operation
- Two-flop synchronizers:
  - `AS_CPU_n` → `as_s`.
  - `MB_DTACK_n` → `mb_s`.
  - Both reset to 1.
- States: SYNC, IDLE, RUN, ACK, FAULT.
- Reset:
  - Enters SYNC.
  - Outputs: `DTACK_CPU_n`=1, `BERR_n`=1, `BUSY`=0.
  - Synchronizers set to 1, timeout counter = 0.
- SYNC: wait for `as_s`=1, then IDLE. This prevents joining a cycle already in progress at reset release.
- IDLE: when `as_s`=0 → RUN and clear the counter.
- RUN: ack source select, fixed priority, evaluated every edge:
  1. `RAM_SEL`=1: `RAM_DTACK_n`=0 → ACK.
  2. else `VPA_n`=0 and `CPUSPACE`=0: `M6800_DTACK_n`=0 → ACK.
  3. else `MB_SEL`=1: `mb_s`=0 → ACK.
  4. else: no ack source; the cycle can only end by timeout.
- RUN, CPU-space cycle with `VPA_n`=0 (autovector): the counter is frozen and no DTACK is issued. The CPU ends the cycle itself; `as_s`=1 → IDLE.
- RUN, `as_s`=1 without ack (aborted cycle): → IDLE, no output change.
- Timeout counter:
  - Width `$clog2(TIMEOUT_CYCLES+1)`.
  - Increments once per edge in RUN and saturates at `TIMEOUT_CYCLES`.
  - Reaching `TIMEOUT_CYCLES` with no ack on that edge → FAULT.
  - Ack and timeout on the same edge: ack wins.
- ACK: `DTACK_CPU_n`=0 until `as_s`=1, then → IDLE with `DTACK_CPU_n`=1 on that same edge.
- FAULT: `BERR_n`=0 and `DTACK_CPU_n`=1 until `as_s`=1, then → IDLE with `BERR_n`=1.
- `DTACK_CPU_n` and `BERR_n` are registered and never both 0.
- `RESET_n`=0 in any state: on the next edge go to SYNC and release both terminations.

## Timing
- `AS_CPU_n` fall to RUN: 3 edges (2 synchronizer, 1 state).
- Ack input low (C7M-domain source) to `DTACK_CPU_n` low: 1 edge.
- `MB_DTACK_n` low to `DTACK_CPU_n` low: 3 edges.
- `AS_CPU_n` rise to termination release: 3 edges.
- The earliest new cycle restarts after IDLE is reached; back-to-back cycles need no idle gap beyond this.
- Timeout: `BERR_n` falls `TIMEOUT_CYCLES` edges after RUN is entered.

## Configuration
- `BUS_TIMEOUT_EN` defined:
  - Watchdog and FAULT state are present, as described above.
- `BUS_TIMEOUT_EN` undefined:
  - Counter and FAULT are removed.
  - RUN waits indefinitely for an ack or for `as_s`=1.
  - `BERR_n` is tied to 1.
  - `TIMEOUT_CYCLES` is ignored.

## Test plan
- Reset held 4 edges with `AS_CPU_n`=0, then released: stays in SYNC, `DTACK_CPU_n`=1, `BERR_n`=1. After `AS_CPU_n`=1 for 3 edges, reaches IDLE.
- RAM cycle: `RAM_SEL`=1, `AS_CPU_n` falls, `RAM_DTACK_n`=0 on edge 5 → `DTACK_CPU_n`=0 on edge 6. `AS_CPU_n` rises → `DTACK_CPU_n`=1 exactly 3 edges later.
- 6800 cycle: `VPA_n`=0, `CPUSPACE`=0, `M6800_DTACK_n` pulses low 20 edges into RUN → `DTACK_CPU_n`=0 one edge later.
- Autovector: `CPUSPACE`=1, `VPA_n`=0, no ack held for 300 edges with `TIMEOUT_CYCLES`=128 → no `BERR_n`, no `DTACK_CPU_n`. `AS_CPU_n` rise → IDLE.
- Timeout: `MB_SEL`=1, `MB_DTACK_n` held high, `TIMEOUT_CYCLES`=128 → `BERR_n`=0 exactly 128 edges after RUN entry. Repeat with `mb_s`=0 arriving on edge 128 → `DTACK_CPU_n`=0, `BERR_n` stays 1.
- Build without `BUS_TIMEOUT_EN`: same unacked motherboard cycle held for 2000 edges → `BERR_n`=1 throughout, `BUSY`=1 until `AS_CPU_n` rises.

Source files
------------

// File: rtl/cycle_terminator_if.sv
// cycle_terminator_if: CPU bus-termination signal bundle between the address
// decoder / ack sources (master side) and the cycle terminator (slave side).
//
// Handshake: a bus cycle is "valid" while AS_CPU_n is low. It is terminated
// by exactly one of DTACK_CPU_n (normal ack) or BERR_n (timeout), which stays
// asserted until AS_CPU_n returns high. The two are never low together.
// BUSY is high from cycle start until the termination has been released.
interface cycle_terminator_if;
  logic AS_CPU_n;
  logic CPUSPACE;
  logic RAM_SEL;
  logic MB_SEL;
  logic VPA_n;
  logic RAM_DTACK_n;
  logic M6800_DTACK_n;
  logic MB_DTACK_n;
  logic DTACK_CPU_n;
  logic BERR_n;
  logic BUSY;

  modport master (
    output AS_CPU_n, CPUSPACE, RAM_SEL, MB_SEL, VPA_n,
    output RAM_DTACK_n, M6800_DTACK_n, MB_DTACK_n,
    input  DTACK_CPU_n, BERR_n, BUSY
  );

  modport slave (
    input  AS_CPU_n, CPUSPACE, RAM_SEL, MB_SEL, VPA_n,
    input  RAM_DTACK_n, M6800_DTACK_n, MB_DTACK_n,
    output DTACK_CPU_n, BERR_n, BUSY
  );
endinterface

// File: rtl/cycle_terminator.sv
// cycle_terminator: merges fast-RAM, 6800-cycle and motherboard acknowledges
// into DTACK_CPU_n for the 68000. All state changes on the falling edge of C7M.
// Optional bus watchdog (BERR_n on timeout) is built when BUS_TIMEOUT_EN is
// defined; otherwise RUN waits forever and BERR_n is tied high.
// state_o exposes the FSM state (SYNC=0, IDLE=1, RUN=2, ACK=3, FAULT=4).
module cycle_terminator #(
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic               C7M,
  input  logic               RESET_n,
  cycle_terminator_if.slave  bus,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    S_SYNC  = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_ACK   = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("cycle_terminator: TIMEOUT_CYCLES must be within 4..1023");
  end

  state_t     state_q, state_d;
  logic       as_meta_q, as_s_q;
  logic       mb_meta_q, mb_s_q;
  // Fills with ones after reset release; as_s_q only reflects the real pin
  // once two edges have passed, so SYNC must not trust the reset value.
  logic [1:0] prime_q;
  logic       dtack_q, dtack_d;
  logic       ack_hit;

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
  logic          autovec;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          berr_q, berr_d;
`endif

  // Two-flop synchronizers for the asynchronous strobe and motherboard ack
  always_ff @(negedge C7M) begin
    if (!RESET_n) begin
      as_meta_q <= 1'b1;
      as_s_q    <= 1'b1;
      mb_meta_q <= 1'b1;
      mb_s_q    <= 1'b1;
      prime_q   <= 2'b00;
    end else begin
      as_meta_q <= bus.AS_CPU_n;
      as_s_q    <= as_meta_q;
      mb_meta_q <= bus.MB_DTACK_n;
      mb_s_q    <= mb_meta_q;
      prime_q   <= {prime_q[0], 1'b1};
    end
  end

  // Fixed-priority ack source select: RAM, then 6800 cycle, then motherboard
  always_comb begin
    ack_hit = 1'b0;
`ifdef BUS_TIMEOUT_EN
    autovec = 1'b0;
`endif
    if (bus.RAM_SEL) begin
      ack_hit = !bus.RAM_DTACK_n;
    end else if (!bus.VPA_n) begin
      if (!bus.CPUSPACE) begin
        ack_hit = !bus.M6800_DTACK_n;
      end
`ifdef BUS_TIMEOUT_EN
      else begin
        // Autovectored interrupt ack: the CPU ends this cycle on its own
        autovec = 1'b1;
      end
`endif
    end else if (bus.MB_SEL) begin
      ack_hit = !mb_s_q;
    end
  end

  // Next-state, watchdog and registered-termination decode
  always_comb begin
    state_d = state_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_SYNC: begin
        if (as_s_q && prime_q[1]) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!as_s_q) begin
          state_d = S_RUN;
`ifdef BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_RUN: begin
        // Strobe release ends the cycle first; an ack beats the timeout
        if (as_s_q) begin
          state_d = S_IDLE;
        end else if (ack_hit) begin
          state_d = S_ACK;
        end
`ifdef BUS_TIMEOUT_EN
        else if (!autovec) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) state_d = S_FAULT;
        end
`endif
      end
      S_ACK: begin
        if (as_s_q) state_d = S_IDLE;
      end
`ifdef BUS_TIMEOUT_EN
      S_FAULT: begin
        if (as_s_q) state_d = S_IDLE;
      end
`endif
      default: state_d = S_SYNC;
    endcase
    // Terminations follow the state being entered, so both are registered
    // and mutually exclusive by construction.
    dtack_d = (state_d != S_ACK);
`ifdef BUS_TIMEOUT_EN
    berr_d  = (state_d != S_FAULT);
`endif
  end

  // FSM state and DTACK register
  always_ff @(negedge C7M) begin
    if (!RESET_n) begin
      state_q <= S_SYNC;
      dtack_q <= 1'b1;
    end else begin
      state_q <= state_d;
      dtack_q <= dtack_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Watchdog counter and BERR register
  always_ff @(negedge C7M) begin
    if (!RESET_n) begin
      cnt_q  <= '0;
      berr_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      berr_q <= berr_d;
    end
  end

  assign bus.BERR_n = berr_q;
`else
  assign bus.BERR_n = 1'b1;
`endif

  assign bus.DTACK_CPU_n = dtack_q;
  assign bus.BUSY        = (state_q == S_RUN) || (state_q == S_ACK) ||
                           (state_q == S_FAULT);
  assign state_o         = state_q;

endmodule

// File: tb/tb_cycle_terminator.sv
// tb_cycle_terminator: directed bench for cycle_terminator. Inputs change and
// outputs are sampled on the rising edge of C7M, midway between active edges.
// Expected {DTACK_CPU_n, BERR_n, BUSY} vectors go through a scoreboard queue.
module tb_cycle_terminator;
  localparam int TO = 128;
  localparam logic [2:0] ST_SYNC  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
`ifdef BUS_TIMEOUT_EN
  localparam logic [2:0] ST_FAULT = 3'd4;
`endif

  logic       C7M = 1'b0;
  logic       RESET_n;
  logic [2:0] state_o;
  int         checks = 0;
  int         failures = 0;
  logic [2:0] exp_q[$];

  cycle_terminator_if bus();

  cycle_terminator #(.TIMEOUT_CYCLES(TO)) dut (
    .C7M     (C7M),
    .RESET_n (RESET_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // Clock
  always #5 C7M = ~C7M;

  // Advance n active (falling) edges, landing on the following rising edge
  task automatic adv(input int n);
    repeat (n) @(posedge C7M);
  endtask

  task automatic expect_outs(input logic dtack, input logic berr, input logic busy);
    exp_q.push_back({dtack, berr, busy});
  endtask

  task automatic check_outs(input string tag);
    logic [2:0] obs;
    logic [2:0] exp;
    obs = {bus.DTACK_CPU_n, bus.BERR_n, bus.BUSY};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty, observed=%b", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s dtack/berr/busy observed=%b expected=%b", tag, obs, exp);
      end
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] exp);
    checks++;
    assert (state_o === exp) else begin
      failures++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state_o, exp);
    end
  endtask

  initial begin
    logic berr_seen;
    logic busy_drop;
    logic dtack_seen;

    RESET_n           = 1'b0;
    bus.AS_CPU_n      = 1'b0;
    bus.CPUSPACE      = 1'b0;
    bus.RAM_SEL       = 1'b0;
    bus.MB_SEL        = 1'b0;
    bus.VPA_n         = 1'b1;
    bus.RAM_DTACK_n   = 1'b1;
    bus.M6800_DTACK_n = 1'b1;
    bus.MB_DTACK_n    = 1'b1;
    @(posedge C7M);

    // Reset with a cycle apparently in progress
    expect_outs(1, 1, 0);
    adv(4);
    check_outs("reset_outs");
    check_state("reset_state", ST_SYNC);
    RESET_n = 1'b1;
    expect_outs(1, 1, 0);
    adv(5);
    check_outs("sync_hold_outs");
    check_state("sync_hold", ST_SYNC);
    bus.AS_CPU_n = 1'b1;
    adv(2);
    check_state("sync_after_2", ST_SYNC);
    adv(1);
    check_state("sync_to_idle", ST_IDLE);

    // Fast RAM cycle
    bus.RAM_SEL = 1'b1;
    bus.AS_CPU_n = 1'b0;
    adv(2);
    check_state("ram_as_2edges", ST_IDLE);
    expect_outs(1, 1, 1);
    adv(1);
    check_outs("ram_run_outs");
    check_state("ram_run", ST_RUN);
    expect_outs(1, 1, 1);
    adv(2);
    check_outs("ram_edge5");
    bus.RAM_DTACK_n = 1'b0;
    expect_outs(0, 1, 1);
    adv(1);
    check_outs("ram_ack_edge6");
    check_state("ram_ack", ST_ACK);
    bus.RAM_DTACK_n = 1'b1;
    bus.AS_CPU_n = 1'b1;
    expect_outs(0, 1, 1);
    adv(2);
    check_outs("ram_release_2");
    expect_outs(1, 1, 0);
    adv(1);
    check_outs("ram_release_3");
    check_state("ram_idle", ST_IDLE);

    // Back-to-back cycle, ack already present on RUN entry
    bus.RAM_DTACK_n = 1'b0;
    bus.AS_CPU_n = 1'b0;
    adv(3);
    check_state("b2b_run", ST_RUN);
    expect_outs(0, 1, 1);
    adv(1);
    check_outs("b2b_ack");
    bus.AS_CPU_n = 1'b1;
    bus.RAM_DTACK_n = 1'b1;
    bus.RAM_SEL = 1'b0;
    expect_outs(1, 1, 0);
    adv(3);
    check_outs("b2b_release");

    // RAM selection masks a motherboard ack
    bus.RAM_SEL = 1'b1;
    bus.MB_SEL = 1'b1;
    bus.MB_DTACK_n = 1'b0;
    bus.AS_CPU_n = 1'b0;
    expect_outs(1, 1, 1);
    adv(8);
    check_outs("prio_ram_over_mb");
    check_state("prio_run", ST_RUN);
    bus.RAM_DTACK_n = 1'b0;
    expect_outs(0, 1, 1);
    adv(1);
    check_outs("prio_ram_ack");
    bus.AS_CPU_n = 1'b1;
    bus.RAM_DTACK_n = 1'b1;
    bus.RAM_SEL = 1'b0;
    bus.MB_SEL = 1'b0;
    bus.MB_DTACK_n = 1'b1;
    expect_outs(1, 1, 0);
    adv(3);
    check_outs("prio_release");

    // 6800 cycle
    bus.VPA_n = 1'b0;
    bus.CPUSPACE = 1'b0;
    bus.AS_CPU_n = 1'b0;
    adv(3);
    check_state("m6800_run", ST_RUN);
    expect_outs(1, 1, 1);
    adv(19);
    check_outs("m6800_wait");
    bus.M6800_DTACK_n = 1'b0;
    expect_outs(0, 1, 1);
    adv(1);
    check_outs("m6800_ack");
    bus.M6800_DTACK_n = 1'b1;
    expect_outs(0, 1, 1);
    adv(2);
    check_outs("m6800_hold");
    bus.AS_CPU_n = 1'b1;
    bus.VPA_n = 1'b1;
    expect_outs(1, 1, 0);
    adv(3);
    check_outs("m6800_release");

    // Aborted cycle with no ack source
    bus.AS_CPU_n = 1'b0;
    expect_outs(1, 1, 1);
    adv(13);
    check_outs("abort_run");
    bus.AS_CPU_n = 1'b1;
    expect_outs(1, 1, 0);
    adv(3);
    check_outs("abort_idle");
    check_state("abort_state", ST_IDLE);

    // Motherboard cycle through the synchronizer
    bus.MB_SEL = 1'b1;
    bus.AS_CPU_n = 1'b0;
    adv(8);
    bus.MB_DTACK_n = 1'b0;
    expect_outs(1, 1, 1);
    adv(2);
    check_outs("mb_sync_2");
    expect_outs(0, 1, 1);
    adv(1);
    check_outs("mb_ack_3");
    bus.AS_CPU_n = 1'b1;
    bus.MB_DTACK_n = 1'b1;
    bus.MB_SEL = 1'b0;
    expect_outs(1, 1, 0);
    adv(3);
    check_outs("mb_release");

    // Autovector: 6800 ack present but must be ignored, no watchdog
    bus.CPUSPACE = 1'b1;
    bus.VPA_n = 1'b0;
    bus.M6800_DTACK_n = 1'b0;
    bus.AS_CPU_n = 1'b0;
    adv(3);
    check_state("autovec_run", ST_RUN);
    expect_outs(1, 1, 1);
    adv(300);
    check_outs("autovec_300");
    check_state("autovec_still_run", ST_RUN);
    bus.AS_CPU_n = 1'b1;
    expect_outs(1, 1, 0);
    adv(3);
    check_outs("autovec_release");
    check_state("autovec_idle", ST_IDLE);
    bus.CPUSPACE = 1'b0;
    bus.VPA_n = 1'b1;
    bus.M6800_DTACK_n = 1'b1;

    // Reset while acknowledging
    bus.RAM_SEL = 1'b1;
    bus.RAM_DTACK_n = 1'b0;
    bus.AS_CPU_n = 1'b0;
    expect_outs(0, 1, 1);
    adv(4);
    check_outs("rst_pre_ack");
    RESET_n = 1'b0;
    expect_outs(1, 1, 0);
    adv(1);
    check_outs("rst_mid_cycle");
    check_state("rst_mid_state", ST_SYNC);
    RESET_n = 1'b1;
    bus.RAM_DTACK_n = 1'b1;
    bus.RAM_SEL = 1'b0;
    adv(4);
    check_state("rst_no_rejoin", ST_SYNC);
    bus.AS_CPU_n = 1'b1;
    adv(3);
    check_state("rst_idle", ST_IDLE);

`ifdef BUS_TIMEOUT_EN
    // Watchdog fires exactly TO edges after RUN entry
    bus.MB_SEL = 1'b1;
    bus.AS_CPU_n = 1'b0;
    adv(3);
    check_state("to_run", ST_RUN);
    expect_outs(1, 1, 1);
    adv(TO - 1);
    check_outs("to_edge_minus1");
    expect_outs(1, 0, 1);
    adv(1);
    check_outs("to_edge_berr");
    check_state("to_fault", ST_FAULT);
    bus.AS_CPU_n = 1'b1;
    expect_outs(1, 0, 1);
    adv(2);
    check_outs("to_release_2");
    expect_outs(1, 1, 0);
    adv(1);
    check_outs("to_release_3");

    // Ack seen on the timeout edge wins
    bus.AS_CPU_n = 1'b0;
    adv(3);
    adv(TO - 3);
    bus.MB_DTACK_n = 1'b0;
    expect_outs(1, 1, 1);
    adv(2);
    check_outs("to_race_pre");
    expect_outs(0, 1, 1);
    adv(1);
    check_outs("to_ack_wins");
    check_state("to_ack_state", ST_ACK);
    bus.AS_CPU_n = 1'b1;
    bus.MB_DTACK_n = 1'b1;
    bus.MB_SEL = 1'b0;
    expect_outs(1, 1, 0);
    adv(3);
    check_outs("to_race_release");
`else
    // Without the watchdog an unanswered cycle waits indefinitely
    bus.MB_SEL = 1'b1;
    bus.AS_CPU_n = 1'b0;
    adv(3);
    check_state("hang_run", ST_RUN);
    berr_seen = 1'b0;
    busy_drop = 1'b0;
    dtack_seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      adv(1);
      if (!bus.BERR_n) berr_seen = 1'b1;
      if (!bus.BUSY) busy_drop = 1'b1;
      if (!bus.DTACK_CPU_n) dtack_seen = 1'b1;
    end
    checks++;
    assert (berr_seen === 1'b0) else begin
      failures++;
      $error("FAIL hang_berr observed_low=%b expected_low=%b", berr_seen, 1'b0);
    end
    checks++;
    assert (busy_drop === 1'b0) else begin
      failures++;
      $error("FAIL hang_busy observed_drop=%b expected_drop=%b", busy_drop, 1'b0);
    end
    checks++;
    assert (dtack_seen === 1'b0) else begin
      failures++;
      $error("FAIL hang_dtack observed_low=%b expected_low=%b", dtack_seen, 1'b0);
    end
    bus.AS_CPU_n = 1'b1;
    bus.MB_SEL = 1'b0;
    expect_outs(1, 1, 0);
    adv(3);
    check_outs("hang_release");
`endif

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
